lcd_ctrl: RTL and testbench

// - 8x8, 8-bit greyscale image processor between an image ROM (IROM) and an image RAM (IRAM).
// - After reset, loads 64 pixels from IROM into an internal buffer.
// - Executes host commands on a 2x2 block located around a movable operation point.
// - On the write command, dumps the buffer to IRAM and pulses done.

---
 rtl/lcd_ctrl.sv | 264 ++++++++++++++++++++++++++
 tb/tb_lcd_ctrl.sv | 361 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_ctrl.sv
// ---------------------------------------------------------------------------
// lcd_ctrl
// 8x8, 8-bit greyscale image processor sitting between an image ROM (IROM)
// and an image RAM (IRAM).
//   - After reset, the 64 pixels are loaded from IROM into an internal buffer.
//   - Host commands operate on a 2x2 block around a movable operation point.
//   - Command 0 dumps the buffer to IRAM and then pulses done.
//
// Ports
//   clk         system clock, all registers on posedge
//   reset       asynchronous, active-high reset
//   cmd[3:0]    command code, sampled when cmd_valid=1 and busy=0
//   cmd_valid   command strobe
//   IROM_rd     IROM read enable (IROM samples IROM_A on negedge)
//   IROM_A[5:0] IROM address
//   IROM_Q[7:0] IROM read data
//   IRAM_valid  IRAM write enable (IRAM writes on negedge)
//   IRAM_D[7:0] IRAM write data
//   IRAM_A[5:0] IRAM write address
//   busy        1 = not accepting commands
//   done        one-cycle pulse after the last IRAM write
//
// Configuration
//   LCD_CTRL_MIRROR_EN  defined: codes 10/11 mirror the block in X / Y.
//                       undefined: codes 10/11 are NOPs with the same timing.
// ---------------------------------------------------------------------------
module lcd_ctrl (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] cmd,
  input  logic       cmd_valid,
  output logic       IROM_rd,
  output logic [5:0] IROM_A,
  input  logic [7:0] IROM_Q,
  output logic       IRAM_valid,
  output logic [7:0] IRAM_D,
  output logic [5:0] IRAM_A,
  output logic       busy,
  output logic       done
);

  typedef enum logic [2:0] {
    S_LOAD,
    S_IDLE,
    S_EXEC,
    S_WRITE,
    S_DONE
  } state_t;

  state_t     state;
  logic [3:0] cmd_q;
  logic [2:0] px;
  logic [2:0] py;
  logic [5:0] wr_idx;
  logic [7:0] img [64];

  // Block addressing: with x,y in 1..7, (y-1,x-1) concatenates directly into
  // the row-major address of P0; the other three never carry across a row.
  logic [2:0] xm1;
  logic [2:0] ym1;
  logic [5:0] a0;
  logic [5:0] a1;
  logic [5:0] a2;
  logic [5:0] a3;

  assign xm1 = px - 3'd1;
  assign ym1 = py - 3'd1;
  assign a0  = {ym1, xm1};
  assign a1  = a0 + 6'd1;
  assign a2  = a0 + 6'd8;
  assign a3  = a0 + 6'd9;

  logic [7:0] p0;
  logic [7:0] p1;
  logic [7:0] p2;
  logic [7:0] p3;

  assign p0 = img[a0];
  assign p1 = img[a1];
  assign p2 = img[a2];
  assign p3 = img[a3];

  // Reductions over the block
  logic [7:0] max01;
  logic [7:0] max23;
  logic [7:0] maxv;
  logic [7:0] min01;
  logic [7:0] min23;
  logic [7:0] minv;
  logic [9:0] sum;
  logic [7:0] avg;

  assign max01 = (p0 > p1) ? p0 : p1;
  assign max23 = (p2 > p3) ? p2 : p3;
  assign maxv  = (max01 > max23) ? max01 : max23;
  assign min01 = (p0 < p1) ? p0 : p1;
  assign min23 = (p2 < p3) ? p2 : p3;
  assign minv  = (min01 < min23) ? min01 : min23;
  assign sum   = {2'b00, p0} + {2'b00, p1} + {2'b00, p2} + {2'b00, p3};
  assign avg   = 8'(sum >> 2);

  // Next block contents for the latched command; unchanged by default so
  // shifts and NOPs write the block back as-is.
  logic [7:0] n0;
  logic [7:0] n1;
  logic [7:0] n2;
  logic [7:0] n3;

  always_comb begin
    n0 = p0;
    n1 = p1;
    n2 = p2;
    n3 = p3;
    case (cmd_q)
      4'd5: begin
        n0 = maxv;
        n1 = maxv;
        n2 = maxv;
        n3 = maxv;
      end
      4'd6: begin
        n0 = minv;
        n1 = minv;
        n2 = minv;
        n3 = minv;
      end
      4'd7: begin
        n0 = avg;
        n1 = avg;
        n2 = avg;
        n3 = avg;
      end
      4'd8: begin
        n0 = p1;
        n1 = p3;
        n3 = p2;
        n2 = p0;
      end
      4'd9: begin
        n0 = p2;
        n2 = p3;
        n3 = p1;
        n1 = p0;
      end
`ifdef LCD_CTRL_MIRROR_EN
      4'd10: begin
        n0 = p2;
        n2 = p0;
        n1 = p3;
        n3 = p1;
      end
      4'd11: begin
        n0 = p1;
        n1 = p0;
        n2 = p3;
        n3 = p2;
      end
`endif
      default: ;
    endcase
  end

  // Pixel buffer. Writes are qualified by FSM state, which is forced to LOAD
  // with IROM_rd=0 during reset, so no write can occur while reset is high.
  logic load_cap;
  logic exec_wr;

  assign load_cap = (state == S_LOAD) && IROM_rd;
  assign exec_wr  = (state == S_EXEC);

  always_ff @(posedge clk) begin
    if (load_cap) begin
      img[IROM_A] <= IROM_Q;
    end else if (exec_wr) begin
      img[a0] <= n0;
      img[a1] <= n1;
      img[a2] <= n2;
      img[a3] <= n3;
    end
  end

  // Control FSM with registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_LOAD;
      busy       <= 1'b1;
      done       <= 1'b0;
      IROM_rd    <= 1'b0;
      IROM_A     <= '0;
      IRAM_valid <= 1'b0;
      IRAM_A     <= '0;
      IRAM_D     <= '0;
      px         <= 3'd4;
      py         <= 3'd4;
      cmd_q      <= '0;
      wr_idx     <= '0;
    end else begin
      case (state)
        S_LOAD: begin
          // First cycle only raises the read; each later cycle captures the
          // pixel addressed by IROM_A (see load_cap) and advances.
          if (!IROM_rd) begin
            IROM_rd <= 1'b1;
            IROM_A  <= '0;
          end else if (IROM_A == 6'd63) begin
            IROM_rd <= 1'b0;
            busy    <= 1'b0;
            state   <= S_IDLE;
          end else begin
            IROM_A <= IROM_A + 6'd1;
          end
        end

        S_IDLE: begin
          if (cmd_valid && !busy) begin
            cmd_q  <= cmd;
            busy   <= 1'b1;
            wr_idx <= '0;
            state  <= (cmd == 4'd0) ? S_WRITE : S_EXEC;
          end
        end

        S_EXEC: begin
          case (cmd_q)
            4'd1: if (py > 3'd1) py <= py - 3'd1;
            4'd2: if (py < 3'd7) py <= py + 3'd1;
            4'd3: if (px > 3'd1) px <= px - 3'd1;
            4'd4: if (px < 3'd7) px <= px + 3'd1;
            default: ;
          endcase
          busy  <= 1'b0;
          state <= S_IDLE;
        end

        S_WRITE: begin
          IRAM_valid <= 1'b1;
          IRAM_A     <= wr_idx;
          IRAM_D     <= img[wr_idx];
          wr_idx     <= wr_idx + 6'd1;
          if (wr_idx == 6'd63) begin
            state <= S_DONE;
          end
        end

        S_DONE: begin
          // Two cycles: first raises done, second drops it and frees busy.
          if (!done) begin
            IRAM_valid <= 1'b0;
            done       <= 1'b1;
          end else begin
            done  <= 1'b0;
            busy  <= 1'b0;
            state <= S_IDLE;
          end
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_ctrl.sv
// ---------------------------------------------------------------------------
// tb_lcd_ctrl
// Self-checking bench for lcd_ctrl: IROM/IRAM behavioural models, a write
// scoreboard fed from a reference image model, a table of block-operation
// vectors, and hand-written sequences for boundaries, the held-valid
// handshake and reset during the IRAM dump.
// ---------------------------------------------------------------------------
module tb_lcd_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] cmd = '0;
  logic       cmd_valid = 1'b0;
  logic       IROM_rd;
  logic [5:0] IROM_A;
  logic [7:0] IROM_Q = '0;
  logic       IRAM_valid;
  logic [7:0] IRAM_D;
  logic [5:0] IRAM_A;
  logic       busy;
  logic       done;

  always #5 clk = ~clk;

  lcd_ctrl dut (
    .clk       (clk),
    .reset     (reset),
    .cmd       (cmd),
    .cmd_valid (cmd_valid),
    .IROM_rd   (IROM_rd),
    .IROM_A    (IROM_A),
    .IROM_Q    (IROM_Q),
    .IRAM_valid(IRAM_valid),
    .IRAM_D    (IRAM_D),
    .IRAM_A    (IRAM_A),
    .busy      (busy),
    .done      (done)
  );

  logic [7:0] rom  [64];
  logic [7:0] ram  [64];
  logic [7:0] mimg [64];
  int mx;
  int my;

  int n_chk = 0;
  int n_fail = 0;
  int done_cnt = 0;
  bit ignore_wr = 1'b0;

  typedef struct packed {
    logic [5:0] a;
    logic [7:0] d;
  } wr_t;
  wr_t exp_q[$];

  typedef struct packed {
    logic [7:0] p0, p1, p2, p3;
    logic [3:0] c;
    logic [7:0] e0, e1, e2, e3;
  } vec_t;

  // IROM: samples address on negedge
  always @(negedge clk) begin
    if (IROM_rd) IROM_Q <= rom[IROM_A];
  end

  // IRAM + scoreboard: writes on negedge
  always @(negedge clk) begin
    wr_t e;
    if (done) done_cnt++;
    if (IRAM_valid) begin
      ram[IRAM_A] = IRAM_D;
      if (!ignore_wr) begin
        n_chk++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL iram_unexpected: got write addr=%0d data=%0d, required no write", IRAM_A, IRAM_D);
        end else begin
          e = exp_q.pop_front();
          if (IRAM_A !== e.a || IRAM_D !== e.d) begin
            n_fail++;
            $display("FAIL iram_write: got addr=%0d data=%0d, required addr=%0d data=%0d",
                     IRAM_A, IRAM_D, e.a, e.d);
          end
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d", nm, act, req);
    end
  endtask

  task automatic fill_rom(input int seed);
    for (int i = 0; i < 64; i++) rom[i] = 8'((i * 29 + seed * 53 + 7) ^ (i << 2));
  endtask

  task automatic set_block(input logic [7:0] b0, input logic [7:0] b1,
                           input logic [7:0] b2, input logic [7:0] b3);
    rom[27] = b0;
    rom[28] = b1;
    rom[35] = b2;
    rom[36] = b3;
  endtask

  // Reference model: (col,row) pixel addressing, written independently
  task automatic model_cmd(input int c);
    int i0, i1, i2, i3, m;
    logic [7:0] q0, q1, q2, q3;
    i0 = (my - 1) * 8 + (mx - 1);
    i1 = (my - 1) * 8 + mx;
    i2 = my * 8 + (mx - 1);
    i3 = my * 8 + mx;
    q0 = mimg[i0]; q1 = mimg[i1]; q2 = mimg[i2]; q3 = mimg[i3];
    case (c)
      1: if (my > 1) my--;
      2: if (my < 7) my++;
      3: if (mx > 1) mx--;
      4: if (mx < 7) mx++;
      5: begin
        m = q0;
        if (q1 > m) m = q1;
        if (q2 > m) m = q2;
        if (q3 > m) m = q3;
        mimg[i0] = 8'(m); mimg[i1] = 8'(m); mimg[i2] = 8'(m); mimg[i3] = 8'(m);
      end
      6: begin
        m = q0;
        if (q1 < m) m = q1;
        if (q2 < m) m = q2;
        if (q3 < m) m = q3;
        mimg[i0] = 8'(m); mimg[i1] = 8'(m); mimg[i2] = 8'(m); mimg[i3] = 8'(m);
      end
      7: begin
        m = (int'(q0) + int'(q1) + int'(q2) + int'(q3)) / 4;
        mimg[i0] = 8'(m); mimg[i1] = 8'(m); mimg[i2] = 8'(m); mimg[i3] = 8'(m);
      end
      8: begin mimg[i0] = q1; mimg[i1] = q3; mimg[i3] = q2; mimg[i2] = q0; end
      9: begin mimg[i0] = q2; mimg[i2] = q3; mimg[i3] = q1; mimg[i1] = q0; end
`ifdef LCD_CTRL_MIRROR_EN
      10: begin mimg[i0] = q2; mimg[i2] = q0; mimg[i1] = q3; mimg[i3] = q1; end
      11: begin mimg[i0] = q1; mimg[i1] = q0; mimg[i2] = q3; mimg[i3] = q2; end
`endif
      default: ;
    endcase
  endtask

  // Reset, check reset outputs, release, and time the LOAD phase
  task automatic do_reset();
    int cnt;
    @(negedge clk);
    reset = 1'b1;
    cmd_valid = 1'b0;
    cmd = '0;
    repeat (3) begin
      @(negedge clk);
      chk("rst_irom_rd", 32'(IROM_rd), 0);
    end
    chk("rst_busy", 32'(busy), 1);
    chk("rst_done", 32'(done), 0);
    chk("rst_irom_a", 32'(IROM_A), 0);
    chk("rst_iram_valid", 32'(IRAM_valid), 0);
    chk("rst_iram_a", 32'(IRAM_A), 0);
    chk("rst_iram_d", 32'(IRAM_D), 0);
    reset = 1'b0;
    cnt = 0;
    @(negedge clk);
    while (busy && cnt < 200) begin
      cnt++;
      @(negedge clk);
    end
    chk("load_busy_cycles", 32'(cnt), 64);
    for (int i = 0; i < 64; i++) mimg[i] = rom[i];
    mx = 4;
    my = 4;
  endtask

  // Present one command once busy is low; returns on the negedge after accept
  task automatic send_cmd(input int c);
    int g;
    g = 0;
    while (busy && g < 500) begin
      @(negedge clk);
      g++;
    end
    chk("cmd_ready", 32'(busy), 0);
    cmd = 4'(c);
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("busy_after_accept", 32'(busy), 1);
    if (c != 0) model_cmd(c);
  endtask

  // Dump to IRAM, scoreboarding every write against the model image
  task automatic write_and_check();
    int cnt;
    int dc0;
    wr_t w;
    for (int i = 0; i < 64; i++) begin
      w.a = 6'(i);
      w.d = mimg[i];
      exp_q.push_back(w);
    end
    dc0 = done_cnt;
    send_cmd(0);
    cnt = 1;
    while (busy && cnt < 300) begin
      @(negedge clk);
      if (busy) cnt++;
    end
    chk("write_busy_cycles", 32'(cnt), 66);
    chk("done_pulses", 32'(done_cnt - dc0), 1);
    chk("writes_pending", 32'(exp_q.size()), 0);
    exp_q.delete();
  endtask

  vec_t vecs[10];

  function automatic vec_t mkv(input int b0, input int b1, input int b2, input int b3,
                               input int c,
                               input int r0, input int r1, input int r2, input int r3);
    vec_t v;
    v.p0 = 8'(b0); v.p1 = 8'(b1); v.p2 = 8'(b2); v.p3 = 8'(b3);
    v.c  = 4'(c);
    v.e0 = 8'(r0); v.e1 = 8'(r1); v.e2 = 8'(r2); v.e3 = 8'(r3);
    return v;
  endfunction

  initial begin
    int seq[12];
    int k, t, t_first, t_last, dc0, m;
    logic [7:0] exp_v;

    vecs[0] = mkv(10, 20, 30, 41, 5, 41, 41, 41, 41);
    vecs[1] = mkv(10, 20, 30, 41, 6, 10, 10, 10, 10);
    vecs[2] = mkv(10, 20, 30, 41, 7, 25, 25, 25, 25);
    vecs[3] = mkv(1, 2, 3, 4, 8, 2, 4, 1, 3);
    vecs[4] = mkv(1, 2, 3, 4, 9, 3, 1, 4, 2);
`ifdef LCD_CTRL_MIRROR_EN
    vecs[5] = mkv(1, 2, 3, 4, 10, 3, 4, 1, 2);
    vecs[6] = mkv(1, 2, 3, 4, 11, 2, 1, 4, 3);
`else
    vecs[5] = mkv(1, 2, 3, 4, 10, 1, 2, 3, 4);
    vecs[6] = mkv(1, 2, 3, 4, 11, 1, 2, 3, 4);
`endif
    vecs[7] = mkv(1, 2, 3, 4, 12, 1, 2, 3, 4);
    vecs[8] = mkv(255, 255, 255, 254, 7, 254, 254, 254, 254);
    vecs[9] = mkv(200, 7, 99, 150, 6, 7, 7, 7, 7);

    // Plain load followed by dump: IRAM must equal IROM
    fill_rom(1);
    do_reset();
    write_and_check();
    for (int i = 0; i < 64; i++) chk("iram_eq_irom", 32'(ram[i]), 32'(rom[i]));

    // Block operations at the reset point (4,4)
    for (int v = 0; v < 10; v++) begin
      fill_rom(2 + v);
      set_block(vecs[v].p0, vecs[v].p1, vecs[v].p2, vecs[v].p3);
      do_reset();
      send_cmd(int'(vecs[v].c));
      write_and_check();
      chk("vec_p0", 32'(ram[27]), 32'(vecs[v].e0));
      chk("vec_p1", 32'(ram[28]), 32'(vecs[v].e1));
      chk("vec_p2", 32'(ram[35]), 32'(vecs[v].e2));
      chk("vec_p3", 32'(ram[36]), 32'(vecs[v].e3));
    end

    // Top-left boundary, then max touches only 0,1,8,9
    fill_rom(20);
    do_reset();
    repeat (7) send_cmd(3);
    repeat (7) send_cmd(1);
    send_cmd(3);
    send_cmd(1);
    send_cmd(5);
    write_and_check();
    m = rom[0];
    if (rom[1] > m) m = rom[1];
    if (rom[8] > m) m = rom[8];
    if (rom[9] > m) m = rom[9];
    for (int i = 0; i < 64; i++) begin
      exp_v = (i == 0 || i == 1 || i == 8 || i == 9) ? 8'(m) : rom[i];
      chk("corner_tl", 32'(ram[i]), 32'(exp_v));
    end

    // Bottom-right boundary, then min touches only 54,55,62,63
    repeat (7) send_cmd(4);
    repeat (7) send_cmd(2);
    send_cmd(4);
    send_cmd(2);
    send_cmd(6);
    write_and_check();
    m = rom[54];
    if (rom[55] < m) m = rom[55];
    if (rom[62] < m) m = rom[62];
    if (rom[63] < m) m = rom[63];
    chk("corner_br_54", 32'(ram[54]), 32'(m));
    chk("corner_br_63", 32'(ram[63]), 32'(m));
    chk("corner_br_53", 32'(ram[53]), 32'(rom[53]));

    // cmd_valid held high: each command accepted once, 2 cycles apart
    fill_rom(30);
    do_reset();
    seq = '{4, 2, 8, 5, 3, 1, 9, 7, 11, 10, 12, 6};
    k = 0;
    t = 0;
    t_first = -1;
    t_last = -1;
    cmd_valid = 1'b1;
    while (k < 12 && t < 100) begin
      if (!busy) begin
        cmd = 4'(seq[k]);
        model_cmd(seq[k]);
        if (k == 0) t_first = t;
        t_last = t;
        k++;
      end
      @(negedge clk);
      t++;
    end
    cmd_valid = 1'b0;
    chk("hold_accepted", 32'(k), 12);
    chk("hold_spacing", 32'(t_last - t_first), 22);
    write_and_check();

    // Reset during the IRAM dump: no done, reload, point back to (4,4)
    fill_rom(40);
    do_reset();
    send_cmd(4);
    send_cmd(5);
    ignore_wr = 1'b1;
    dc0 = done_cnt;
    send_cmd(0);
    repeat (20) @(negedge clk);
    chk("write_in_progress", 32'(IRAM_valid), 1);
    fill_rom(41);
    do_reset();
    repeat (10) @(negedge clk);
    chk("abort_no_done", 32'(done_cnt - dc0), 0);
    ignore_wr = 1'b0;
    send_cmd(5);
    write_and_check();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
